// File: rtl/sa_pkg.sv
// Shared types and elaboration-time helpers for the systolic-array tile sequencer.
// Contents: sequencer state enum, BEATS/DRAIN derivations, clog2 helpers.
package sa_pkg;

   typedef enum logic [2:0] {
      SEQ_IDLE    = 3'd0,
      SEQ_FILL    = 3'd1,
      SEQ_STEP    = 3'd2,
      SEQ_DRAIN   = 3'd3,
      SEQ_CAPTURE = 3'd4,
      SEQ_UNLOAD  = 3'd5,
      SEQ_DONE    = 3'd6
   } sa_seq_state_t;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int unsigned sa_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

   // Counter width: never narrower than one bit.
   function automatic int unsigned sa_cw(input int unsigned n);
      return (sa_clog2(n) == 0) ? 1 : sa_clog2(n);
   endfunction

   // Operand beats per K-step.
   function automatic int unsigned sa_beats(input int unsigned size, input int unsigned input_width);
      return size / input_width;
   endfunction

   // Skew-shifter advances needed to flush the array after the last K-step.
   function automatic int unsigned sa_drain(input int unsigned size);
      return 2 * size;
   endfunction

endpackage

// File: rtl/sa_seq_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count compare.
// Ports: clk, rst (async high), clr, en, last (terminal value), cnt, tc_c (cnt == last).
module sa_seq_counter
#(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic [W-1:0] cnt,
   output logic         tc_c
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + W'(1);
   end

   assign tc_c = (cnt == last);

endmodule

// File: rtl/sa_tile_sequencer.sv
// Control FSM for one systolic-array tile wrapper: gathers operand beats per K-step,
// steps the skew shifters, drains the array, captures results and unloads them
// under sink backpressure.
// Ports: clk, rst (async high); start/k_len job request; busy/done status;
//        in_valid/in_ready operand handshake; i_s_enable, i_enable, pass_w_enable,
//        pass_r_enable wrapper enables; out_valid/out_ready/out_idx result stream.
// Build option: define SA_SEQ_PERF_CNT_EN to add stall_in_cnt / stall_out_cnt.
module sa_tile_sequencer
   import sa_pkg::*;
#(
   parameter int unsigned SIZE        = 32,
   parameter int unsigned INPUT_WIDTH = 4,
   parameter int unsigned KW          = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [KW-1:0]             k_len,
   output logic                      busy,
   output logic                      done,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      i_s_enable,
   output logic                      i_enable,
   output logic                      pass_w_enable,
   output logic                      pass_r_enable,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [sa_cw(SIZE)-1:0]    out_idx
`ifdef SA_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]               stall_in_cnt,
   output logic [31:0]               stall_out_cnt
`endif
);

   localparam int unsigned BEATS = sa_beats(SIZE, INPUT_WIDTH);
   localparam int unsigned DRAIN = sa_drain(SIZE);
   localparam int unsigned BW    = sa_cw(BEATS);
   localparam int unsigned DW    = sa_cw(DRAIN);
   localparam int unsigned IDXW  = sa_cw(SIZE);

   localparam logic [BW-1:0]   BEAT_LAST  = BW'(BEATS - 1);
   localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN - 1);
   localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(SIZE - 1);

   sa_seq_state_t state_q, state_d;
   logic [KW-1:0] k_len_q;

   logic            beat_clr, beat_en, beat_tc;
   logic            kcnt_clr, kcnt_en, kcnt_tc;
   logic            drain_clr, drain_en, drain_tc;
   logic            idx_clr, idx_en, idx_tc;
   logic [BW-1:0]   beat_cnt;
   logic [KW-1:0]   kcnt;
   logic [DW-1:0]   drain_cnt;
   logic [IDXW-1:0] idx_cnt;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= SEQ_IDLE;
      else     state_q <= state_d;
   end

   // Job depth captured when a start is taken in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                k_len_q <= '0;
      else if (state_q == SEQ_IDLE && start)  k_len_q <= k_len;
   end

   // Next-state, wrapper enables and counter controls.
   always_comb begin
      state_d       = state_q;
      busy          = 1'b1;
      done          = 1'b0;
      in_ready      = 1'b0;
      i_s_enable    = 1'b0;
      i_enable      = 1'b0;
      pass_w_enable = 1'b0;
      pass_r_enable = 1'b0;
      out_valid     = 1'b0;
      beat_clr      = 1'b0;
      beat_en       = 1'b0;
      kcnt_clr      = 1'b0;
      kcnt_en       = 1'b0;
      drain_clr     = 1'b0;
      drain_en      = 1'b0;
      idx_clr       = 1'b0;
      idx_en        = 1'b0;
      case (state_q)
         SEQ_IDLE: begin
            busy = 1'b0;
            if (start) begin
               kcnt_clr = 1'b1;
               beat_clr = 1'b1;
               state_d  = (k_len != '0) ? SEQ_FILL : SEQ_DONE;
            end
         end
         SEQ_FILL: begin
            in_ready   = 1'b1;
            i_s_enable = in_valid;
            beat_en    = in_valid;
            if (in_valid && beat_tc) state_d = SEQ_STEP;
         end
         SEQ_STEP: begin
            i_enable  = 1'b1;
            kcnt_en   = 1'b1;
            beat_clr  = 1'b1;
            drain_clr = 1'b1;
            state_d   = kcnt_tc ? SEQ_DRAIN : SEQ_FILL;
         end
         SEQ_DRAIN: begin
            i_enable = 1'b1;
            drain_en = 1'b1;
            if (drain_tc) state_d = SEQ_CAPTURE;
         end
         SEQ_CAPTURE: begin
            pass_w_enable = 1'b1;
            idx_clr       = 1'b1;
            state_d       = SEQ_UNLOAD;
         end
         SEQ_UNLOAD: begin
            out_valid     = 1'b1;
            pass_r_enable = out_ready;
            idx_en        = out_ready;
            if (out_ready && idx_tc) state_d = SEQ_DONE;
         end
         SEQ_DONE: begin
            done    = 1'b1;
            state_d = SEQ_IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = SEQ_IDLE;
         end
      endcase
   end

   sa_seq_counter #(.W(BW)) u_beat (
      .clk(clk), .rst(rst), .clr(beat_clr), .en(beat_en),
      .last(BEAT_LAST), .cnt(beat_cnt), .tc_c(beat_tc)
   );

   // k_len_q is non-zero whenever this compare is consulted.
   sa_seq_counter #(.W(KW)) u_kcnt (
      .clk(clk), .rst(rst), .clr(kcnt_clr), .en(kcnt_en),
      .last(k_len_q - KW'(1)), .cnt(kcnt), .tc_c(kcnt_tc)
   );

   sa_seq_counter #(.W(DW)) u_drain (
      .clk(clk), .rst(rst), .clr(drain_clr), .en(drain_en),
      .last(DRAIN_LAST), .cnt(drain_cnt), .tc_c(drain_tc)
   );

   sa_seq_counter #(.W(IDXW)) u_idx (
      .clk(clk), .rst(rst), .clr(idx_clr), .en(idx_en),
      .last(IDX_LAST), .cnt(idx_cnt), .tc_c(idx_tc)
   );

   assign out_idx = idx_cnt;

`ifdef SA_SEQ_PERF_CNT_EN
   // Saturating stall counters; cleared by a start taken in IDLE, held otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_in_cnt  <= '0;
         stall_out_cnt <= '0;
      end else if (state_q == SEQ_IDLE && start) begin
         stall_in_cnt  <= '0;
         stall_out_cnt <= '0;
      end else begin
         if (state_q == SEQ_FILL && !in_valid && stall_in_cnt != '1)
            stall_in_cnt <= stall_in_cnt + 32'd1;
         if (state_q == SEQ_UNLOAD && !out_ready && stall_out_cnt != '1)
            stall_out_cnt <= stall_out_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Scoreboard bench for sa_tile_sequencer (SIZE=4, INPUT_WIDTH=2).
// Each job's input/ready patterns are fixed up front; a transaction-level model walks
// them to predict transfer cycles, the done cycle and enable totals.
module tb_sa_tile_sequencer;

   localparam int S   = 4;
   localparam int IW  = 2;
   localparam int KW  = 9;
   localparam int B   = S / IW;
   localparam int D   = 2 * S;
   localparam int LEN = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [KW-1:0] k_len;
   logic          busy, done;
   logic          in_valid, in_ready, i_s_enable, i_enable;
   logic          pass_w_enable, pass_r_enable;
   logic          out_ready, out_valid;
   logic [1:0]    out_idx;
`ifdef SA_SEQ_PERF_CNT_EN
   logic [31:0]   stall_in_cnt, stall_out_cnt;
`endif

   sa_tile_sequencer #(.SIZE(S), .INPUT_WIDTH(IW), .KW(KW)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len),
      .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready),
      .i_s_enable(i_s_enable), .i_enable(i_enable),
      .pass_w_enable(pass_w_enable), .pass_r_enable(pass_r_enable),
      .out_ready(out_ready), .out_valid(out_valid), .out_idx(out_idx)
`ifdef SA_SEQ_PERF_CNT_EN
      , .stall_in_cnt(stall_in_cnt), .stall_out_cnt(stall_out_cnt)
`endif
   );

   always #5 clk = ~clk;

   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   typedef struct {
      int c0; int done_c;
      int n_is; int n_ie; int n_pw; int n_pr;
      int st_in; int st_out;
   } job_t;
   typedef struct { int c; int idx; } xfer_t;

   job_t  job_q[$];
   xfer_t xfer_q[$];
   int    vectors = 0;
   int    errors  = 0;
   int    last_lat = -1;
   bit    iv[LEN];
   bit    orv[LEN];

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit iv_at(input int i);
      return (i < LEN) ? iv[i] : 1'b1;
   endfunction

   function automatic bit or_at(input int i);
      return (i < LEN) ? orv[i] : 1'b1;
   endfunction

   // Monitor: per-cycle protocol rules plus scoreboard pops on transfers and done.
   int    m_is, m_ie, m_pw, m_pr;
   int    hold_in, hold_out;
   bit    exp_busy, inv_ok;
   job_t  mj;
   xfer_t mx;
   always @(negedge clk) begin
      if (rst) begin
         m_is = 0; m_ie = 0; m_pw = 0; m_pr = 0;
         hold_in = 0; hold_out = 0;
      end else begin
         exp_busy = (job_q.size() > 0) && (ecnt > job_q[0].c0) && (ecnt <= job_q[0].done_c);
         chk("busy", busy, exp_busy);
         inv_ok = !(pass_w_enable && pass_r_enable)
               && (i_s_enable == (in_valid && in_ready))
               && (pass_r_enable == (out_valid && out_ready))
               && ($countones({in_ready, i_enable, pass_w_enable, out_valid, done}) <= 1)
               && (busy || !(in_ready || i_enable || pass_w_enable || out_valid || done));
         vectors++;
         if (!inv_ok) begin
            errors++;
            $display("FAIL invariants: got busy/rdy/isen/ien/pw/pr/ov/done=%b%b%b%b%b%b%b%b iv=%b or=%b, required a consistent enable set",
                     busy, in_ready, i_s_enable, i_enable, pass_w_enable, pass_r_enable, out_valid, done,
                     in_valid, out_ready);
         end
         m_is += int'(i_s_enable);
         m_ie += int'(i_enable);
         m_pw += int'(pass_w_enable);
         m_pr += int'(pass_r_enable);
         if (out_valid && out_ready) begin
            if (xfer_q.size() == 0) chk("xfer_unexpected", ecnt, -1);
            else begin
               mx = xfer_q.pop_front();
               chk("xfer_cycle", ecnt, mx.c);
               chk("xfer_idx", out_idx, mx.idx);
            end
         end
         if (done) begin
            if (job_q.size() == 0) chk("done_unexpected", 1, 0);
            else begin
               mj = job_q.pop_front();
               chk("done_cycle", ecnt, mj.done_c);
               chk("n_i_s_enable", m_is, mj.n_is);
               chk("n_i_enable", m_ie, mj.n_ie);
               chk("n_pass_w", m_pw, mj.n_pw);
               chk("n_pass_r", m_pr, mj.n_pr);
               last_lat = ecnt - mj.c0;
`ifdef SA_SEQ_PERF_CNT_EN
               chk("stall_in_cnt", stall_in_cnt, mj.st_in);
               chk("stall_out_cnt", stall_out_cnt, mj.st_out);
`endif
               hold_in  = mj.st_in;
               hold_out = mj.st_out;
            end
            m_is = 0; m_ie = 0; m_pw = 0; m_pr = 0;
         end
`ifdef SA_SEQ_PERF_CNT_EN
         if (!busy) begin
            chk("stall_in_hold", stall_in_cnt, hold_in);
            chk("stall_out_hold", stall_out_cnt, hold_out);
         end
`endif
      end
   end

   task automatic idle(input int n);
      start    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // mode: 0 all-ready, 1 random, 2 five-cycle in_valid gap in step 2, 3 out_ready toggle.
   task automatic run_job(input int k, input int mode, input int busy_rel, input int rst_rel);
      int   t, acc, idx, st_in, st_out, c0, brel;
      job_t j;
      int   tog[7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < LEN; i++) begin
         iv[i]  = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
         orv[i] = (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
      end
      if (mode == 2) for (int i = 5; i <= 9; i++) iv[i] = 1'b0;
      if (mode == 3) for (int i = 0; i < 7; i++) orv[13 + i] = (tog[i] != 0);

      c0 = ecnt;
      st_in = 0; st_out = 0;
      t = 1;
      if (k > 0) begin
         for (int s = 0; s < k; s++) begin
            acc = 0;
            while (acc < B) begin
               if (iv_at(t)) acc++;
               else st_in++;
               t++;
            end
            t++;
         end
         t += D + 1;
         idx = 0;
         while (idx < S) begin
            if (or_at(t)) begin
               xfer_q.push_back('{c: c0 + t, idx: idx});
               idx++;
            end else st_out++;
            t++;
         end
      end
      j.c0 = c0; j.done_c = c0 + t;
      j.n_is = k * B; j.n_ie = (k > 0) ? k + D : 0;
      j.n_pw = (k > 0) ? 1 : 0; j.n_pr = (k > 0) ? S : 0;
      j.st_in = st_in; j.st_out = st_out;
      job_q.push_back(j);
      last_lat = -1;
      brel = (busy_rel == -2) ? int'($urandom_range(t, 1)) : busy_rel;

      for (int rel = 0; rel <= t + 2; rel++) begin
         start     = (rel == 0) || (rel == brel);
         k_len     = (rel == 0) ? KW'(k) : KW'($urandom);
         in_valid  = iv_at(rel);
         out_ready = or_at(rel);
         if (rel == rst_rel) begin
            #1 rst = 1'b1;
            #1;
            chk("rst_mid_outputs",
                {busy, done, in_ready, i_s_enable, i_enable, pass_w_enable, pass_r_enable, out_valid, out_idx}, 0);
`ifdef SA_SEQ_PERF_CNT_EN
            chk("rst_mid_stall", {stall_in_cnt, stall_out_cnt}, 0);
`endif
            job_q.delete();
            xfer_q.delete();
            @(posedge clk);
            #1 rst = 1'b0;
            start = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      if (job_q.size() != 0) begin
         chk("done_timeout", job_q.size(), 0);
         job_q.delete();
         xfer_q.delete();
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {busy, done, in_ready, i_s_enable, i_enable, pass_w_enable, pass_r_enable, out_valid, out_idx}, 0);
      rst = 1'b0;
      idle(2);

      run_job(1, 0, -1, -1);
      chk("lat_k1", last_lat, 17);

      run_job(3, 2, -1, -1);
      chk("lat_k3_gap", last_lat, 28);
`ifdef SA_SEQ_PERF_CNT_EN
      chk("stall_in_s2", stall_in_cnt, 5);
`endif

      run_job(1, 3, -1, -1);
      chk("lat_k1_backpressure", last_lat, 20);
`ifdef SA_SEQ_PERF_CNT_EN
      chk("stall_out_s3", stall_out_cnt, 3);
`endif

      run_job(0, 0, -1, -1);
      chk("lat_k0", last_lat, 1);

      run_job(2, 0, 5, -1);
      chk("lat_k2_busy_start", last_lat, 20);

      run_job(1, 0, -1, 6);
      idle(3);
      run_job(1, 0, -1, -1);
      chk("lat_after_rst", last_lat, 17);

      for (int n = 0; n < 40; n++) begin
         run_job(int'($urandom_range(6, 0)), 1, ($urandom_range(1) != 0) ? -2 : -1, -1);
         idle(int'($urandom_range(2, 0)));
      end

      idle(4);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
